pro_memory_loader: RTL

- Parametrised successor to the fixed instruction ROM.
- Adds a runtime program-load port, synchronous registered fetch with a valid strobe, and out-of-range address detection.
- Sits between the program counter and the instruction decoder. An external loader (testbench or boot logic) streams a program in before the core runs.

---
 rtl/pro_memory_loader_if.sv | 29 ++
 rtl/pro_memory_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/pro_memory_loader_if.sv
// Program-load and fetch bus between the loader/core side and the program memory.
// The master side streams words in and issues fetches; the slave side is the memory.
interface pro_memory_loader_if #(
  parameter int INSTR_WIDTH = 17,
  parameter int ADDR_WIDTH  = 8
);
  logic                   load_start;
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   load_ready;
  logic [ADDR_WIDTH:0]    load_count;
  logic [ADDR_WIDTH-1:0]  prg_counter;
  logic                   fetch_req;
  logic [INSTR_WIDTH-1:0] instructions;
  logic                   instr_valid;
  logic                   addr_fault;
  logic                   busy;

  modport master (
    output load_start, load_valid, load_data, load_last, prg_counter, fetch_req,
    input  load_ready, load_count, instructions, instr_valid, addr_fault, busy
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, prg_counter, fetch_req,
    output load_ready, load_count, instructions, instr_valid, addr_fault, busy
  );
endinterface

// File: rtl/pro_memory_loader.sv
// Loadable program memory: streams a program in, then serves registered
// one-cycle-latency fetches with a valid strobe and out-of-range detection.
module pro_memory_loader #(
  parameter int INSTR_WIDTH = 17,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256
) (
  input logic                clk,
  input logic                reset,
  pro_memory_loader_if.slave bus
);

  // state | meaning
  // IDLE  | no program loaded, fetches ignored
  // LOAD  | accepting load beats
  // RUN   | serving fetches
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_t                 state, state_nxt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH:0]    count, count_nxt;
  logic                   wr_en;
  logic                   in_range;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   fault_q;

  assign in_range = ({1'b0, bus.prg_counter} < DEPTH_W);

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
          count_nxt  = '0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          // restart: earlier words stay in the array, only the session resets
          wr_ptr_nxt = '0;
          count_nxt  = '0;
        end else if (bus.load_valid) begin
          wr_en     = 1'b1;
          count_nxt = count + 1'b1;
          if (wr_ptr != LAST_PTR) wr_ptr_nxt = wr_ptr + 1'b1;
          if (bus.load_last || (count_nxt == DEPTH_W)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
          count_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      count   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      count   <= count_nxt;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      if ((state == RUN) && bus.fetch_req) begin
        valid_q <= 1'b1;
        if (in_range) begin
          instr_q <= mem[bus.prg_counter[IDX_W-1:0]];
        end else begin
          instr_q <= '0;
          fault_q <= 1'b1;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= bus.load_data;
  end

  assign bus.load_ready   = (state == LOAD);
  assign bus.busy         = (state == LOAD);
  assign bus.load_count   = count;
  assign bus.instructions = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.addr_fault   = fault_q;

endmodule
